// File: rtl/mem_access_pkg.sv
// Shared MEM-stage definitions: widths, access-size codes, FSM states, watchdog limit.
// Pure declarations; no latency or flow-control of its own.
package mem_access_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_e;

    localparam logic [7:0] WDOG_LIMIT = 8'd255;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    // Size codes other than byte/half are checked as full words.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-lane select and zero/sign extension; sub-word sizes only with MEM_SUBWORD_EN.
// Latency: purely combinational; backpressure: none.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [REG_W-1:0]  load_data
);

`ifdef MEM_SUBWORD_EN
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: load_data = rdata;
        endcase
    end
`else
    // Word-only build: lane select and extension collapse to a pass-through.
    logic unused_cfg;
    assign unused_cfg = ^{addr_lo, size, sign_ext};
    assign load_data  = rdata;
`endif

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access FSM (IDLE/ACCESS/DONE) with watchdog; MEM_SUBWORD_EN enables byte/half.
// Latency: >=1 ACCESS cycle then one DONE cycle; stalls the pipeline until dmemReady or watchdog expiry.
module mem_access
    import mem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] memALUOut,
    input  logic [WORD_W-1:0] memWriteData,
    input  logic              memMemRead,
    input  logic              memMemWrite,
    input  logic [1:0]        memSize,
    input  logic              memSignExt,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [WORD_W-1:0] dmemAddr,
    output logic [WORD_W-1:0] dmemWData,
    output logic [BE_W-1:0]   dmemByteEn,
    input  logic              dmemReady,
    input  logic [WORD_W-1:0] dmemRData,
    output logic [REG_W-1:0]  memMemOut,
    output logic              memStall,
    output logic              memAlignErr,
    output logic              memBusErr
);

    mem_state_e        state_q, state_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [REG_W-1:0]  mem_out_q, mem_out_d;
    logic              align_err_q, align_err_d;
    logic              bus_err_q, bus_err_d;

    logic [1:0]        eff_size;
    logic              mem_op;
    logic              misaligned;
    logic [REG_W-1:0]  load_data;
    dmem_req_t         bus;

`ifdef MEM_SUBWORD_EN
    assign eff_size = memSize;
`else
    assign eff_size = SZ_WORD;
`endif

    assign mem_op     = memMemRead | memMemWrite;
    assign misaligned = is_misaligned(eff_size, memALUOut[1:0]);

    mem_lane_align u_lane_align (
        .rdata     (dmemRData),
        .addr_lo   (memALUOut[1:0]),
        .size      (memSize),
        .sign_ext  (memSignExt),
        .load_data (load_data)
    );

    // Request fields come straight from the frozen MEM-stage register, so they
    // stay stable for as long as the stall holds the pipeline.
    always_comb begin
        bus.we    = memMemWrite;
        bus.addr  = {memALUOut[WORD_W-1:2], 2'b00};
        bus.wdata = memWriteData;
        bus.be    = '1;
        case (eff_size)
            SZ_BYTE: begin
                bus.be    = 4'b0001 << memALUOut[1:0];
                bus.wdata = {4{memWriteData[7:0]}};
            end
            SZ_HALF: begin
                bus.be    = 4'b0011 << memALUOut[1:0];
                bus.wdata = {2{memWriteData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        mem_out_d   = mem_out_q;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        memStall    = 1'b0;
        dmemReq     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        align_err_d = 1'b1;
                    end else begin
                        state_d  = ST_ACCESS;
                        wdog_d   = '0;
                        memStall = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                memStall = 1'b1;
                dmemReq  = 1'b1;
                if (dmemReady) begin
                    if (!memMemWrite) begin
                        mem_out_d = load_data;
                    end
                    state_d = ST_DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_d == WDOG_LIMIT) begin
                        bus_err_d = 1'b1;
                        mem_out_d = '0;
                        state_d   = ST_DONE;
                    end
                end
            end
            // One free cycle lets the pipeline advance past this instruction.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            memStall = 1'b0;
            dmemReq  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wdog_q      <= '0;
            mem_out_q   <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            mem_out_q   <= mem_out_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign dmemWe      = dmemReq & bus.we;
    assign dmemAddr    = dmemReq ? bus.addr  : '0;
    assign dmemWData   = dmemReq ? bus.wdata : '0;
    assign dmemByteEn  = dmemReq ? bus.be    : '0;
    assign memMemOut   = mem_out_q;
    assign memAlignErr = align_err_q;
    assign memBusErr   = bus_err_q;

endmodule
